// File: rtl/spilling_rx_uc.sv
// spilling_rx_uc: receive-side control unit of the Spilling serial link.
// Reassembles a 12-byte measurement frame (3 sensors x "DDD#") arriving from
// the UART receiver, validates every byte, and publishes three 3-digit BCD
// distances together with a one-cycle pronto. Malformed frames and inter-byte
// timeouts abort the frame with a one-cycle erro.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-low reset
//   dado_rx    received byte, valid while pronto_rx is high
//   pronto_rx  one-cycle strobe per received byte
//   medida0-2  published BCD distance per sensor, {hundreds, tens, units}
//   pronto     one-cycle pulse: new frame published
//   erro       one-cycle pulse: frame aborted
//   db_estado  current state code for debug displays (1111 = unknown code)
module spilling_rx_uc #(
  parameter int unsigned TIMEOUT = 5_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  dado_rx,
  input  logic        pronto_rx,
  output logic [11:0] medida0,
  output logic [11:0] medida1,
  output logic [11:0] medida2,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int unsigned GapW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Leaving espera on the cycle the counter would reach TIMEOUT-1.
  localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT - 2);

  typedef enum logic [3:0] {
    StInicial    = 4'b0000,
    StEspera     = 4'b0001,
    StVerifica   = 4'b0010,
    StProxByte   = 4'b0011,
    StProxSensor = 4'b0100,
    StFinal      = 4'b0101,
    StErro       = 4'b0110
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          byte_q;
  logic [1:0]          q3_q;      // byte index within a sensor group
  logic [1:0]          q2_q;      // sensor index
  logic [GapW-1:0]     gap_q;
  // Index 2 of the packed dimension is the hundreds digit.
  logic [2:0][3:0]     shadow_q [0:2];
  logic [2:0][3:0]     medida_q [0:2];

  logic is_digit;
  logic is_sep;

  assign is_digit = (byte_q[7:4] == 4'h3) && (byte_q[3:0] <= 4'd9);
  assign is_sep   = (byte_q == 8'h23);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInicial: begin
        if (pronto_rx) state_d = StVerifica;
      end
      StEspera: begin
        // A byte arriving on the timeout cycle takes priority.
        if (pronto_rx)               state_d = StVerifica;
        else if (gap_q == GapLast)   state_d = StErro;
      end
      StVerifica: begin
        if (q3_q != 2'd3) begin
          state_d = is_digit ? StProxByte : StErro;
        end else if (is_sep) begin
          state_d = (q2_q == 2'd2) ? StFinal : StProxSensor;
        end else begin
          state_d = StErro;
        end
      end
      StProxByte:   state_d = StEspera;
      StProxSensor: state_d = StEspera;
      StFinal:      state_d = StInicial;
      StErro:       state_d = StInicial;
      default:      state_d = StInicial;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StInicial;
      byte_q   <= '0;
      q3_q     <= '0;
      q2_q     <= '0;
      gap_q    <= '0;
      for (int s = 0; s < 3; s++) begin
        shadow_q[s] <= '0;
        medida_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        StInicial: begin
          gap_q <= '0;
          if (pronto_rx) byte_q <= dado_rx;
        end
        StEspera: begin
          if (pronto_rx) begin
            byte_q <= dado_rx;
            gap_q  <= '0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        StVerifica: begin
          gap_q <= '0;
          if (state_d == StProxByte) begin
            shadow_q[q2_q][2'd2 - q3_q] <= byte_q[3:0];
          end
          // Publish the whole frame at once on the edge entering est_final.
          if (state_d == StFinal) begin
            for (int s = 0; s < 3; s++) medida_q[s] <= shadow_q[s];
          end
        end
        StProxByte: begin
          q3_q <= q3_q + 1'b1;
        end
        StProxSensor: begin
          q3_q <= '0;
          q2_q <= q2_q + 1'b1;
        end
        StFinal: begin
          q3_q <= '0;
          q2_q <= '0;
        end
        StErro: begin
          q3_q <= '0;
          q2_q <= '0;
          for (int s = 0; s < 3; s++) shadow_q[s] <= '0;
        end
        default: begin
          q3_q  <= '0;
          q2_q  <= '0;
          gap_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    pronto    = (state_q == StFinal);
    erro      = (state_q == StErro);
    db_estado = 4'b1111;
    case (state_q)
      StInicial, StEspera, StVerifica, StProxByte,
      StProxSensor, StFinal, StErro: db_estado = state_q;
      default:                       db_estado = 4'b1111;
    endcase
  end

  assign medida0 = medida_q[0];
  assign medida1 = medida_q[1];
  assign medida2 = medida_q[2];

endmodule

// File: tb/tb_spilling_rx_uc.sv
// Directed testbench for spilling_rx_uc, run with TIMEOUT = 20.
module tb_spilling_rx_uc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  dado_rx = 8'h00;
  logic        pronto_rx = 1'b0;
  logic [11:0] medida0, medida1, medida2;
  logic        pronto, erro;
  logic [3:0]  db_estado;

  int checks = 0;
  int errors = 0;
  int pronto_cnt = 0;
  int erro_cnt = 0;

  spilling_rx_uc #(.TIMEOUT(20)) dut (
    .clock     (clock),
    .reset     (reset),
    .dado_rx   (dado_rx),
    .pronto_rx (pronto_rx),
    .medida0   (medida0),
    .medida1   (medida1),
    .medida2   (medida2),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (pronto === 1'b1) pronto_cnt++;
    if (erro === 1'b1) erro_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Strobe one byte; returns 1 ns after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    dado_rx   = b;
    pronto_rx = 1'b1;
    @(posedge clock);
    #1;
    pronto_rx = 1'b0;
  endtask

  // Byte spacing is gap+1 clock cycles.
  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      idle(gap);
    end
  endtask

  task automatic check_vals(input string tag, input logic [11:0] e0, input logic [11:0] e1,
                            input logic [11:0] e2);
    check({tag, "_m0"}, medida0, e0);
    check({tag, "_m1"}, medida1, e1);
    check({tag, "_m2"}, medida2, e2);
  endtask

  initial begin
    int p0, e0, found;

    // Reset state
    #12;
    check("rst_db", db_estado, 4'b0000);
    check("rst_pronto", pronto, 1'b0);
    check("rst_erro", erro, 1'b0);
    check_vals("rst", 12'h000, 12'h000, 12'h000);
    @(negedge clock);
    reset = 1'b1;
    idle(2);

    // Valid frame, 10-cycle spacing
    send_byte("1");
    check("f1_verifica", db_estado, 4'b0010);
    idle(1);
    check("f1_prox_byte", db_estado, 4'b0011);
    idle(1);
    check("f1_espera", db_estado, 4'b0001);
    idle(7);
    send_str("23#045#900", 9);
    send_byte("#");
    check("f1_last_verifica", db_estado, 4'b0010);
    check("f1_no_early_pub", medida0, 12'h000);
    idle(1);
    check("f1_pronto", pronto, 1'b1);
    check("f1_db_final", db_estado, 4'b0101);
    check_vals("f1", 12'h123, 12'h045, 12'h900);
    idle(1);
    check("f1_pronto_low", pronto, 1'b0);
    check("f1_db_inicial", db_estado, 4'b0000);
    check("f1_pronto_cnt", pronto_cnt, 1);
    check("f1_erro_cnt", erro_cnt, 0);
    idle(5);

    // Bad digit, then a valid frame
    send_str("12", 9);
    send_byte("A");
    idle(1);
    check("bad_erro", erro, 1'b1);
    check("bad_db", db_estado, 4'b0110);
    idle(1);
    check("bad_erro_low", erro, 1'b0);
    check("bad_db_inicial", db_estado, 4'b0000);
    check_vals("bad_keep", 12'h123, 12'h045, 12'h900);
    idle(5);
    send_str("007#008#009#", 9);
    check_vals("f2", 12'h007, 12'h008, 12'h009);
    check("f2_pronto_cnt", pronto_cnt, 2);
    check("f2_erro_cnt", erro_cnt, 1);

    // Missing separator
    send_str("123", 9);
    send_byte("4");
    idle(1);
    check("sep_erro", erro, 1'b1);
    idle(1);
    check("sep_db_inicial", db_estado, 4'b0000);
    check_vals("sep_keep", 12'h007, 12'h008, 12'h009);
    idle(5);

    // Inter-byte timeout
    p0 = pronto_cnt;
    e0 = erro_cnt;
    found = -1;
    send_byte("5");
    idle(9);
    send_byte("5");
    for (int i = 1; i <= 40; i++) begin
      idle(1);
      if (erro === 1'b1) begin
        found = i;
        break;
      end
    end
    check("to_window", (found >= 20 && found <= 22), 1'b1);
    idle(100);
    check("to_erro_once", erro_cnt, e0 + 1);
    check("to_no_pronto", pronto_cnt, p0);
    check("to_idle_db", db_estado, 4'b0000);

    // Asynchronous reset mid-frame
    send_str("123#04", 9);
    #3;
    reset = 1'b0;
    #1;
    check_vals("arst", 12'h000, 12'h000, 12'h000);
    check("arst_db", db_estado, 4'b0000);
    check("arst_pronto", pronto, 1'b0);
    check("arst_erro", erro, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    idle(2);
    send_str("321#654#98", 9);
    send_byte("7");
    idle(9);
    send_byte("#");
    idle(1);
    check("f3_pronto", pronto, 1'b1);
    check_vals("f3", 12'h321, 12'h654, 12'h987);
    idle(3);

    // Back-to-back frames at 3-cycle spacing
    p0 = pronto_cnt;
    e0 = erro_cnt;
    send_str("111#222#333", 2);
    send_byte("#");
    idle(1);
    check("b1_pronto", pronto, 1'b1);
    check_vals("b1", 12'h111, 12'h222, 12'h333);
    idle(1);
    send_str("444#555#666", 2);
    send_byte("#");
    idle(1);
    check("b2_pronto", pronto, 1'b1);
    check_vals("b2", 12'h444, 12'h555, 12'h666);
    idle(2);
    check("b2_pronto_cnt", pronto_cnt, p0 + 2);
    check("b2_erro_cnt", erro_cnt, e0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
